// File: rtl/controle_movimento.sv
// Grid motion controller: requests a nearest-target search, validates the result and
// walks the robot there one step at a time through a command/step-done handshake.
module controle_movimento #(
    parameter int TamanhoMalha     = 8,
    parameter int tamanhoDistancia = 8,
    parameter int TimeoutCiclos    = 1000
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        iniciar,
    input  logic                        abortar,
    input  logic                        carregarPosicao,
    input  logic [tamanhoDistancia-1:0] posicaoInicialX,
    input  logic [tamanhoDistancia-1:0] posicaoInicialY,
    input  logic                        operacaoFinalizada,
    input  logic [tamanhoDistancia-1:0] destinoX,
    input  logic [tamanhoDistancia-1:0] destinoY,
    output logic                        novoDado,
    output logic [tamanhoDistancia-1:0] posicaoAtualnoEixoX,
    output logic [tamanhoDistancia-1:0] posicaoAtualnoEixoY,
    output logic [2:0]                  comando,
    output logic                        comandoValido,
    input  logic                        comandoAceito,
    input  logic                        passoConcluido,
    output logic                        chegou,
    output logic                        ocupado,
    output logic [1:0]                  erro,
    output logic [3:0]                  estado
);
    localparam int W  = tamanhoDistancia;
    localparam int CW = $clog2(TimeoutCiclos) + 1;
    localparam logic [W:0]    LIMITE = (W+1)'(TamanhoMalha);
    localparam logic [CW-1:0] TLIM   = CW'(TimeoutCiclos - 1);

    localparam logic [2:0] CMD_PARADO = 3'd0;
    localparam logic [2:0] CMD_MAIS_X = 3'd1;
    localparam logic [2:0] CMD_MENOS_X = 3'd2;
    localparam logic [2:0] CMD_MAIS_Y = 3'd3;
    localparam logic [2:0] CMD_MENOS_Y = 3'd4;

    localparam logic [1:0] ERR_NENHUM  = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_DESTINO = 2'b10;

    typedef enum logic [3:0] {
        OCIOSO, SOLICITA, AGUARDA, VALIDA, CALCULA,
        EMITE, EXECUTA, ATUALIZA, CHEGOU, ERRO
    } estado_t;

    estado_t       state, nextState;
    logic [W-1:0]  destX, destY;
    logic [2:0]    cmdLatched, cmdCalc, cmdNext;
    logic [1:0]    erroCode;
    logic [CW-1:0] timeoutCnt;
    logic          destInvalido;
    logic          emitindo;

    assign estado = state;
    assign destInvalido = ({1'b0, destX} >= LIMITE) || ({1'b0, destY} >= LIMITE);

    // X is resolved before Y; PARADO means the robot is already on the target.
    always_comb begin
        cmdCalc = CMD_PARADO;
        if (destX > posicaoAtualnoEixoX)      cmdCalc = CMD_MAIS_X;
        else if (destX < posicaoAtualnoEixoX) cmdCalc = CMD_MENOS_X;
        else if (destY > posicaoAtualnoEixoY) cmdCalc = CMD_MAIS_Y;
        else if (destY < posicaoAtualnoEixoY) cmdCalc = CMD_MENOS_Y;
    end

    // Handshake: a command transfers on the rising edge where comandoValido and
    // comandoAceito are both high; comando is frozen from the first valid cycle
    // until that edge. passoConcluido is only honoured after the transfer.
    always_comb begin
        nextState = state;
        erroCode  = erro;
        if (abortar) begin
            nextState = OCIOSO;
        end else begin
            case (state)
                OCIOSO:   if (iniciar) nextState = SOLICITA;
                SOLICITA: nextState = AGUARDA;
                AGUARDA:  if (operacaoFinalizada) nextState = VALIDA;
                VALIDA: begin
                    if (destInvalido) begin
                        nextState = ERRO;
                        erroCode  = ERR_DESTINO;
                    end else begin
                        nextState = CALCULA;
                    end
                end
                CALCULA:  nextState = (cmdCalc == CMD_PARADO) ? CHEGOU : EMITE;
                EMITE:    if (comandoAceito) nextState = EXECUTA;
                EXECUTA: begin
                    if (passoConcluido) begin
                        nextState = ATUALIZA;
                    end else if (timeoutCnt == TLIM) begin
                        nextState = ERRO;
                        erroCode  = ERR_TIMEOUT;
                    end
                end
                ATUALIZA: nextState = CALCULA;
                CHEGOU:   nextState = OCIOSO;
                ERRO:     if (iniciar) nextState = SOLICITA;
                default:  nextState = OCIOSO;
            endcase
        end
    end

    assign emitindo = (nextState == EMITE) || (nextState == EXECUTA) || (nextState == ATUALIZA);
    assign cmdNext  = (state == CALCULA) ? cmdCalc : cmdLatched;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= OCIOSO;
            destX      <= '0;
            destY      <= '0;
            cmdLatched <= CMD_PARADO;
            timeoutCnt <= '0;
        end else begin
            state <= nextState;
            if (state == AGUARDA && operacaoFinalizada && !abortar) begin
                destX <= destinoX;
                destY <= destinoY;
            end
            if (state == CALCULA) cmdLatched <= cmdCalc;
            timeoutCnt <= (state == EXECUTA) ? timeoutCnt + 1'b1 : '0;
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            novoDado      <= 1'b0;
            comandoValido <= 1'b0;
            comando       <= CMD_PARADO;
            chegou        <= 1'b0;
            ocupado       <= 1'b0;
            erro          <= ERR_NENHUM;
        end else begin
            novoDado      <= (nextState == SOLICITA);
            comandoValido <= (nextState == EMITE);
            comando       <= emitindo ? cmdNext : CMD_PARADO;
            chegou        <= (nextState == CHEGOU);
            ocupado       <= (nextState != OCIOSO);
            erro          <= (nextState == ERRO) ? erroCode : ERR_NENHUM;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            posicaoAtualnoEixoX <= '0;
            posicaoAtualnoEixoY <= '0;
        end else if (!abortar) begin
            if (state == OCIOSO && carregarPosicao) begin
                posicaoAtualnoEixoX <= posicaoInicialX;
                posicaoAtualnoEixoY <= posicaoInicialY;
            end else if (state == ATUALIZA) begin
                case (cmdLatched)
                    CMD_MAIS_X:  posicaoAtualnoEixoX <= posicaoAtualnoEixoX + W'(1);
                    CMD_MENOS_X: posicaoAtualnoEixoX <= posicaoAtualnoEixoX - W'(1);
                    CMD_MAIS_Y:  posicaoAtualnoEixoY <= posicaoAtualnoEixoY + W'(1);
                    CMD_MENOS_Y: posicaoAtualnoEixoY <= posicaoAtualnoEixoY - W'(1);
                    default: ;
                endcase
            end
        end
    end
endmodule
